cvxif_copro_responder: RTL and testbench

- Responder (coprocessor) end of the CV-X-IF offload interface that the issue stage drives via x_issue_valid/x_issue_ready/x_off_instr.
- Decodes offloaded custom-0 instructions, accepts or rejects each in the issue handshake, and executes accepted ones: single-cycle add or iterative shift-add multiply.
- Returns one result per handshaken instruction, tagged with its trans_id, through a result FIFO feeding a writeback port.
- Reference coprocessor for bring-up and verification of the offload path.

---
 rtl/cvxif_copro_responder_if.sv | 33 +++
 rtl/cvxif_copro_responder.sv | 193 +++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF issue and result channels between the issue stage (master) and a coprocessor (slave).
// Signal suffixes are from the responder's point of view.
interface cvxif_copro_responder_if #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     x_issue_valid_i;
  logic                     x_issue_ready_o;
  logic [31:0]              x_off_instr_i;
  logic [TRANS_ID_BITS-1:0] x_trans_id_i;
  logic [XLEN-1:0]          x_rs1_i;
  logic [XLEN-1:0]          x_rs2_i;
  logic                     x_accept_o;
  logic                     x_writeback_o;
  logic                     x_result_valid_o;
  logic                     x_result_ready_i;
  logic [TRANS_ID_BITS-1:0] x_result_trans_id_o;
  logic [XLEN-1:0]          x_result_data_o;
  logic                     x_result_we_o;
  logic                     x_result_exc_o;

  modport slave (
    input  x_issue_valid_i, x_off_instr_i, x_trans_id_i, x_rs1_i, x_rs2_i, x_result_ready_i,
    output x_issue_ready_o, x_accept_o, x_writeback_o, x_result_valid_o,
           x_result_trans_id_o, x_result_data_o, x_result_we_o, x_result_exc_o
  );

  modport master (
    output x_issue_valid_i, x_off_instr_i, x_trans_id_i, x_rs1_i, x_rs2_i, x_result_ready_i,
    input  x_issue_ready_o, x_accept_o, x_writeback_o, x_result_valid_o,
           x_result_trans_id_o, x_result_data_o, x_result_we_o, x_result_exc_o
  );
endinterface

// File: rtl/cvxif_copro_responder.sv
// Reference CV-X-IF coprocessor: decodes custom-0 CADD/CMUL/CNOP, runs a shift-add multiplier,
// and returns one tagged result per issued instruction through a small result FIFO.
module cvxif_copro_responder #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  cvxif_copro_responder_if.slave x_if
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STEP_W = $clog2(XLEN);

  localparam logic [6:0]        OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0]        F3_CADD     = 3'b000;
  localparam logic [2:0]        F3_CMUL     = 3'b001;
  localparam logic [2:0]        F3_CNOP     = 3'b010;
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(XLEN - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
    logic                     we;
    logic                     exc;
  } entry_t;

  state_e                   state_q;
  logic [XLEN-1:0]          mcand_q;
  logic [XLEN-1:0]          mplier_q;
  logic [XLEN-1:0]          acc_q;
  logic [STEP_W-1:0]        step_q;
  logic [TRANS_ID_BITS-1:0] mul_id_q;

  entry_t                   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic                     is_cadd_s;
  logic                     is_cmul_s;
  logic                     is_cnop_s;
  logic                     accept_s;
  logic                     issue_ready_s;
  logic                     xfer_s;
  logic [XLEN-1:0]          acc_sum_s;
  logic                     push_s;
  entry_t                   push_entry_s;
  logic                     fifo_empty_s;
  logic                     pop_s;
  entry_t                   head_s;

  // Instruction decode: only custom-0 with a known funct3 is recognised.
  always_comb begin
    is_cadd_s = 1'b0;
    is_cmul_s = 1'b0;
    is_cnop_s = 1'b0;
    if (x_if.x_off_instr_i[6:0] == OPC_CUSTOM0) begin
      case (x_if.x_off_instr_i[14:12])
        F3_CADD: is_cadd_s = 1'b1;
        F3_CMUL: is_cmul_s = 1'b1;
        F3_CNOP: is_cnop_s = 1'b1;
        default: is_cadd_s = 1'b0;
      endcase
    end else begin
      is_cadd_s = 1'b0;
    end
  end

  assign accept_s      = is_cadd_s | is_cmul_s | is_cnop_s;
  assign issue_ready_s = (state_q == IDLE) && (count_q < DEPTH_C);
  assign xfer_s        = x_if.x_issue_valid_i && issue_ready_s;
  assign acc_sum_s     = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});

  assign x_if.x_issue_ready_o = issue_ready_s;
  assign x_if.x_accept_o      = accept_s;
  assign x_if.x_writeback_o   = is_cadd_s | is_cmul_s;

  // Multiply sequencer: one shift-add step per MUL cycle, XLEN steps in total.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      mul_id_q <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      mul_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_s && is_cmul_s) begin
            state_q  <= MUL;
            mcand_q  <= x_if.x_rs1_i;
            mplier_q <= x_if.x_rs2_i;
            acc_q    <= '0;
            step_q   <= '0;
            mul_id_q <= x_if.x_trans_id_i;
          end else begin
            state_q  <= IDLE;
          end
        end
        MUL: begin
          acc_q    <= acc_sum_s;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            state_q <= IDLE;
          end else begin
            state_q <= MUL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result source select; an issue can never coincide with the final multiply step.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = '0;
    if ((state_q == MUL) && (step_q == LAST_STEP)) begin
      push_s            = 1'b1;
      push_entry_s.id   = mul_id_q;
      push_entry_s.data = acc_sum_s;
      push_entry_s.we   = 1'b1;
      push_entry_s.exc  = 1'b0;
    end else if (xfer_s && !is_cmul_s) begin
      push_s            = 1'b1;
      push_entry_s.id   = x_if.x_trans_id_i;
      push_entry_s.data = is_cadd_s ? (x_if.x_rs1_i + x_if.x_rs2_i) : {XLEN{1'b0}};
      push_entry_s.we   = is_cadd_s;
      push_entry_s.exc  = !accept_s;
    end else begin
      push_s = 1'b0;
    end
  end

  assign fifo_empty_s = (count_q == '0);
  assign pop_s        = !fifo_empty_s && x_if.x_result_ready_i;

  // Result FIFO storage and occupancy; flush drops everything, including a same-cycle push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_entry_s;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_s = fifo_empty_s ? entry_t'('0) : mem_q[rd_ptr_q];

  assign x_if.x_result_valid_o    = !fifo_empty_s;
  assign x_if.x_result_trans_id_o = head_s.id;
  assign x_if.x_result_data_o     = head_s.data;
  assign x_if.x_result_we_o       = head_s.we;
  assign x_if.x_result_exc_o      = head_s.exc;
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed vectors, multi-cycle corner cases,
// and random traffic checked against a queue-based model of the result stream.
module tb_cvxif_copro_responder;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned TID   = 3;
  localparam int unsigned DEPTH = 4;

  localparam logic [31:0] I_CADD = 32'h0000_000B;
  localparam logic [31:0] I_CMUL = 32'h0000_100B;
  localparam logic [31:0] I_CNOP = 32'h0000_200B;
  localparam logic [31:0] I_OP   = 32'h0000_0033;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic flush_i = 1'b0;

  always #5 clk_i = ~clk_i;

  cvxif_copro_responder_if #(.XLEN(XLEN), .TRANS_ID_BITS(TID)) x_if ();

  cvxif_copro_responder #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .x_if    (x_if)
  );

  typedef struct {
    logic [TID-1:0] id;
    logic [63:0]    data;
    logic           we;
    logic           exc;
  } res_t;

  typedef struct {
    logic [31:0]    instr;
    logic [TID-1:0] id;
    logic [63:0]    rs1;
    logic [63:0]    rs2;
    logic           exp_acc;
    logic           exp_wb;
    logic [63:0]    exp_data;
    logic           exp_we;
    logic           exp_exc;
  } vec_t;

  // Model: results waiting at the port, plus one multiply in flight with a cycle countdown.
  res_t exp_q[$];
  bit   mul_busy = 1'b0;
  int   mul_left = 0;
  res_t mul_res;

  int n_vec = 0;
  int n_err = 0;
  bit acc_s, wb_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [31:0] ins);
    if (ins[6:0] != 7'b0001011) return 0;
    case (ins[14:12])
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  // One clock: drive at negedge, check all outputs against the model, advance the model at posedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [TID-1:0] id,
                      input logic [63:0] a, input logic [63:0] b, input bit rr, input bit fl,
                      output bit acc_o, output bit wb_o);
    bit   m_ready, xfer, pop;
    int   k;
    res_t r;
    @(negedge clk_i);
    x_if.x_issue_valid_i  = v;
    x_if.x_off_instr_i    = ins;
    x_if.x_trans_id_i     = id;
    x_if.x_rs1_i          = a;
    x_if.x_rs2_i          = b;
    x_if.x_result_ready_i = rr;
    flush_i               = fl;
    #1;
    k       = kind_of(ins);
    m_ready = !mul_busy && (exp_q.size() < DEPTH);
    chk("issue_ready", 64'(x_if.x_issue_ready_o), 64'(m_ready));
    if (v) begin
      chk("accept", 64'(x_if.x_accept_o), 64'(k != 0));
      chk("writeback", 64'(x_if.x_writeback_o), 64'(k == 1 || k == 2));
    end
    chk("result_valid", 64'(x_if.x_result_valid_o), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("head_id", 64'(x_if.x_result_trans_id_o), 64'(exp_q[0].id));
      chk("head_data", x_if.x_result_data_o, exp_q[0].data);
      chk("head_we_exc", 64'({x_if.x_result_we_o, x_if.x_result_exc_o}),
          64'({exp_q[0].we, exp_q[0].exc}));
    end else begin
      chk("empty_head_data", x_if.x_result_data_o, 64'd0);
      chk("empty_head_flags", 64'({x_if.x_result_trans_id_o, x_if.x_result_we_o, x_if.x_result_exc_o}),
          64'd0);
    end
    acc_o = x_if.x_accept_o;
    wb_o  = x_if.x_writeback_o;
    xfer  = v && m_ready;
    pop   = rr && (exp_q.size() > 0);
    @(posedge clk_i);
    if (fl) begin
      exp_q.delete();
      mul_busy = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (mul_busy) begin
        mul_left--;
        if (mul_left == 0) begin
          exp_q.push_back(mul_res);
          mul_busy = 1'b0;
        end
      end
      if (xfer) begin
        r.id = id;
        case (k)
          1: begin r.data = a + b;  r.we = 1'b1; r.exc = 1'b0; end
          2: begin r.data = a * b;  r.we = 1'b1; r.exc = 1'b0; end
          3: begin r.data = 64'd0;  r.we = 1'b0; r.exc = 1'b0; end
          default: begin r.data = 64'd0; r.we = 1'b0; r.exc = 1'b1; end
        endcase
        if (k == 2) begin
          mul_busy = 1'b1;
          mul_left = XLEN;
          mul_res  = r;
        end else begin
          exp_q.push_back(r);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 3'd0, 64'd0, 64'd0, rr, 1'b0, acc_s, wb_s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] ins;
    int          sel;

    x_if.x_issue_valid_i  = 1'b0;
    x_if.x_off_instr_i    = 32'd0;
    x_if.x_trans_id_i     = 3'd0;
    x_if.x_rs1_i          = 64'd0;
    x_if.x_rs2_i          = 64'd0;
    x_if.x_result_ready_i = 1'b0;

    // Reset state
    #2;
    chk("rst_issue_ready", 64'(x_if.x_issue_ready_o), 64'd1);
    chk("rst_result_valid", 64'(x_if.x_result_valid_o), 64'd0);
    chk("rst_result_data", x_if.x_result_data_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single-cycle instructions, result consumed the cycle after it appears
    vecs[0] = '{I_CADD, 3'd3, 64'd5, 64'd7, 1'b1, 1'b1, 64'd12, 1'b1, 1'b0};
    vecs[1] = '{I_CADD, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0};
    vecs[2] = '{I_OP, 3'd2, 64'd9, 64'd9, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1};
    vecs[3] = '{I_CNOP, 3'd4, 64'd9, 64'd9, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_300B, 3'd5, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_002B, 3'd7, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1};
    vecs[6] = '{32'hABCD_0F8B, 3'd0, 64'h1234, 64'h1111, 1'b1, 1'b1, 64'h2345, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].instr, vecs[i].id, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0, acc_s, wb_s);
      chk("vec_accept", 64'(acc_s), 64'(vecs[i].exp_acc));
      chk("vec_writeback", 64'(wb_s), 64'(vecs[i].exp_wb));
      chk("vec_valid", 64'(x_if.x_result_valid_o), 64'd1);
      chk("vec_id", 64'(x_if.x_result_trans_id_o), 64'(vecs[i].id));
      chk("vec_data", x_if.x_result_data_o, vecs[i].exp_data);
      chk("vec_we", 64'(x_if.x_result_we_o), 64'(vecs[i].exp_we));
      chk("vec_exc", 64'(x_if.x_result_exc_o), 64'(vecs[i].exp_exc));
    end
    idle(2, 1'b1);

    // CMUL latency: ready low for XLEN cycles, result XLEN+1 cycles after the handshake
    step(1'b1, I_CMUL, 3'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, acc_s, wb_s);
    for (int c = 1; c <= XLEN; c++) begin
      chk("mul_busy_ready", 64'(x_if.x_issue_ready_o), 64'd0);
      chk("mul_busy_valid", 64'(x_if.x_result_valid_o), 64'd0);
      idle(1, 1'b1);
    end
    chk("mul_valid", 64'(x_if.x_result_valid_o), 64'd1);
    chk("mul_data", x_if.x_result_data_o, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_id", 64'(x_if.x_result_trans_id_o), 64'd1);
    chk("mul_ready_again", 64'(x_if.x_issue_ready_o), 64'd1);
    idle(2, 1'b1);

    // Full FIFO back-pressure and ordering
    for (int i = 0; i < 4; i++)
      step(1'b1, I_CADD, 3'(i), 64'(i), 64'd100, 1'b0, 1'b0, acc_s, wb_s);
    chk("full_ready", 64'(x_if.x_issue_ready_o), 64'd0);
    step(1'b1, I_CADD, 3'd4, 64'd40, 64'd4, 1'b0, 1'b0, acc_s, wb_s);
    chk("full_wait_ready", 64'(x_if.x_issue_ready_o), 64'd0);
    chk("full_head0", 64'(x_if.x_result_trans_id_o), 64'd0);
    step(1'b1, I_CADD, 3'd4, 64'd40, 64'd4, 1'b1, 1'b0, acc_s, wb_s);
    chk("pop_ready", 64'(x_if.x_issue_ready_o), 64'd1);
    step(1'b1, I_CADD, 3'd4, 64'd40, 64'd4, 1'b0, 1'b0, acc_s, wb_s);
    for (int i = 1; i <= 4; i++) begin
      chk("order_id", 64'(x_if.x_result_trans_id_o), 64'(i));
      idle(1, 1'b1);
    end
    chk("order_drained", 64'(x_if.x_result_valid_o), 64'd0);

    // Flush mid-multiply with results queued
    step(1'b1, I_CADD, 3'd6, 64'd1, 64'd2, 1'b0, 1'b0, acc_s, wb_s);
    step(1'b1, I_CADD, 3'd7, 64'd3, 64'd4, 1'b0, 1'b0, acc_s, wb_s);
    step(1'b1, I_CMUL, 3'd5, 64'd9, 64'd9, 1'b0, 1'b0, acc_s, wb_s);
    idle(9, 1'b0);
    step(1'b1, I_CADD, 3'd3, 64'd1, 64'd1, 1'b0, 1'b1, acc_s, wb_s);
    chk("flush_valid", 64'(x_if.x_result_valid_o), 64'd0);
    chk("flush_ready", 64'(x_if.x_issue_ready_o), 64'd1);
    idle(XLEN + 8, 1'b1);
    chk("flush_no_mul", 64'(x_if.x_result_valid_o), 64'd0);

    // Asynchronous reset mid-multiply
    step(1'b1, I_CADD, 3'd6, 64'd10, 64'd20, 1'b0, 1'b0, acc_s, wb_s);
    step(1'b1, I_CMUL, 3'd7, 64'd5, 64'd6, 1'b0, 1'b0, acc_s, wb_s);
    idle(20, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(x_if.x_result_valid_o), 64'd0);
    chk("arst_data", x_if.x_result_data_o, 64'd0);
    chk("arst_flags", 64'({x_if.x_result_trans_id_o, x_if.x_result_we_o, x_if.x_result_exc_o}), 64'd0);
    chk("arst_ready", 64'(x_if.x_issue_ready_o), 64'd1);
    exp_q.delete();
    mul_busy = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(XLEN + 8, 1'b1);
    step(1'b1, I_CADD, 3'd2, 64'd1, 64'd1, 1'b1, 1'b0, acc_s, wb_s);
    chk("post_rst_add", x_if.x_result_data_o, 64'd2);
    idle(2, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 19);
      ins = $urandom;
      if (sel < 8) begin
        ins[6:0] = 7'b0001011; ins[14:12] = 3'b000;
      end else if (sel < 9) begin
        ins[6:0] = 7'b0001011; ins[14:12] = 3'b001;
      end else if (sel < 13) begin
        ins[6:0] = 7'b0001011; ins[14:12] = 3'b010;
      end else if (sel < 16) begin
        ins[6:0] = 7'b0001011; ins[14:12] = 3'($urandom_range(3, 7));
      end else begin
        ins[6:0] = 7'($urandom);
      end
      step(($urandom_range(0, 9) < 7), ins, 3'($urandom),
           {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom},
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 149) == 0), acc_s, wb_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
